// File: rtl/imm_ctrl_pkg.sv
// Shared constants and FSM state type for the immediate shift/merge arbiter.
package imm_ctrl_pkg;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    localparam logic MODE_LUI  = 1'b0;
    localparam logic MODE_LI32 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MERGE = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/imm_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after rr_ptr, wrapping.
module imm_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  rr_ptr,
    input  logic                     enable,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  idx
);

    localparam int PTR_W = $clog2(NREQ);

    int   cand_s;
    logic found_s;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = (int'(rr_ptr) + k) % NREQ;
            if (enable && !found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = PTR_W'(cand_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/shift_left_sixteen.sv
// Exact left shift by SIZE bits: the input lands in the upper half, lower half is zero.
module shift_left_sixteen #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0]   din,
    output logic [2*SIZE-1:0] dout
);

    assign dout = {din, {SIZE{1'b0}}};

endmodule

// File: rtl/imm_shift_arbiter.sv
// Round-robin shares one 16-bit left shifter among NREQ requesters, producing
// LUI (imm<<16) or LI32 ((imm<<16)|lo) results on a tagged valid/ready port.
module imm_shift_arbiter
    import imm_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*IMM_W-1:0] req_imm,
    input  logic [NREQ*IMM_W-1:0] req_lo,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  busy
);

    state_t              state_r;
    logic [TAG_W-1:0]    rr_ptr_r;
    logic [IMM_W-1:0]    imm_q_r;
    logic [IMM_W-1:0]    lo_q_r;
    logic                mode_q_r;
    logic [TAG_W-1:0]    tag_q_r;
    logic [DATA_W-1:0]   acc_r;
    logic                res_valid_r;
    logic [DATA_W-1:0]   res_data_r;
    logic [TAG_W-1:0]    res_tag_r;

    logic                arb_en_s;
    logic [NREQ-1:0]     grant_s;
    logic [TAG_W-1:0]    gidx_s;
    logic                handshake_s;
    logic [DATA_W-1:0]   shift_s;

    // Grants are offered only in IDLE and never while reset is asserted.
    assign arb_en_s    = (state_r == IDLE) && rst_n;
    assign handshake_s = arb_en_s && (|grant_s);

    imm_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .enable (arb_en_s),
        .grant  (grant_s),
        .idx    (gidx_s)
    );

    shift_left_sixteen #(.SIZE(IMM_W)) u_shift (
        .din  (imm_q_r),
        .dout (shift_s)
    );

    assign req_ready = grant_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_tag   = res_tag_r;
    assign busy      = (state_r != IDLE);

    // Control FSM with request capture and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            imm_q_r     <= '0;
            lo_q_r      <= '0;
            mode_q_r    <= MODE_LUI;
            tag_q_r     <= '0;
            acc_r       <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_tag_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        imm_q_r  <= req_imm[gidx_s*IMM_W +: IMM_W];
                        lo_q_r   <= req_lo[gidx_s*IMM_W +: IMM_W];
                        mode_q_r <= req_mode[gidx_s];
                        tag_q_r  <= gidx_s;
                        rr_ptr_r <= (gidx_s == TAG_W'(NREQ-1)) ? '0 : gidx_s + TAG_W'(1);
                        state_r  <= SHIFT;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_r <= shift_s;
                    if (mode_q_r == MODE_LUI) begin
                        res_data_r  <= shift_s;
                        res_tag_r   <= tag_q_r;
                        res_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end else begin
                        state_r     <= MERGE;
                    end
                end
                MERGE: begin
                    // Lower half of acc is always zero, so the OR is a pure merge.
                    res_data_r  <= acc_r | {{(DATA_W-IMM_W){1'b0}}, lo_q_r};
                    res_tag_r   <= tag_q_r;
                    res_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= HOLD;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
